muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Iterative multiply/divide unit for the pipelined MIPS core, sequencing MULT/MULTU/DIV/DIVU over WIDTH cycles and owning the HI/LO registers.
- Sits beside the EX-stage ALU. The decode/ALU-control path issues start/op, and the hazard unit uses busy to stall MFHI/MFLO and any new mul/div.
- Uses one radix-2 shift-add or restoring-subtract step per cycle.

Parameters:
WIDTH, 32, operand width; HI and LO are WIDTH bits each.
CNT_W (localparam), $clog2(WIDTH+1), width of the iteration counter.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request to begin an operation; sampled on the rising edge of clock.
op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
rs_val  input  WIDTH  multiplicand or dividend.
rt_val  input  WIDTH  multiplier or divisor.
busy  output  1  high while an operation is in flight; used as the stall source.
done  output  1  one-cycle pulse; hi/lo are valid from this cycle.
div_by_zero  output  1  high together with done when a divide had rt_val==0.
hi  output  WIDTH  HI register: product upper half, or remainder.
lo  output  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Reset (async, immediate): state=IDLE, count=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0. Reset mid-operation aborts it; no partial result is written.
- States: IDLE, RUN, FIX, DONE. busy = (state==RUN or FIX), decoded combinationally from state. done = (state==DONE).
- Accept: start is accepted at edge E0 only when state is IDLE or DONE. start during RUN/FIX is ignored; the in-flight operation and its operands are unaffected.
- At accept, latch:
  - sign flags: op[0]=1 means signed;
  - operand magnitudes: two's-complement absolute value if signed;
  - op.
  Then set count=0 and state=RUN.
- Divide by zero (op[1]=1, rt_val==0) at accept: go straight to DONE. Write hi=rs_val (raw, unsigned view), lo=all ones, div_by_zero=1. done is high in the cycle after E0; busy never asserts.
- RUN, multiply: each edge, if the accumulator LSB is 1, add the multiplicand to the upper half with carry (WIDTH+1-bit add), then shift the {carry,upper,lower} accumulator right by 1.
- RUN, divide (restoring): shift {rem,quot} left by 1; trial = rem − divisor (WIDTH+1 bits). If trial is non-negative, rem=trial and quot LSB=1.
- RUN ends after exactly WIDTH iterations (edges E1..E_WIDTH); at E_WIDTH, state→FIX.
- FIX (one edge, E_WIDTH+1): apply sign correction and write hi/lo; state→DONE.
  - Signed mult: negate the 2·WIDTH-bit product if the operand signs differ.
  - Signed div: negate the quotient if the signs differ; negate the remainder if the dividend is negative.
- Timing: done is high WIDTH+1 cycles after the accept edge (33 at WIDTH=32). busy is high for WIDTH+1 cycles.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000 (two's-complement wrap) and hi=0. No flag is raised.
- DONE: lasts one cycle, then state→IDLE unless start is accepted (back-to-back allowed, state→RUN). div_by_zero clears on leaving DONE.
- hi/lo hold their values until the next operation's FIX edge or the div-by-zero DONE write. They are never cleared except by reset.

Test Plan:
1. MULTU 0xFFFFFFFF×0xFFFFFFFF → done exactly 33 cycles after the accept edge; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
2. MULT 0xFFFFFFFD(−3)×0x00000007 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then back-to-back MULT 0x00010000×0x00010000 started in the DONE cycle → hi=0x00000001, lo=0x00000000.
3. DIVU 100/7 → lo=14, hi=2. DIV 0xFFFFFFF9(−7)/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU 5/0 → done 1 cycle after accept, busy never high; hi=5, lo=0xFFFFFFFF, div_by_zero=1 for one cycle only.
5. Start DIVU 100/7, then pulse start with MULTU 3×3 at cycle 5 → second request ignored; result lo=14, hi=2 at cycle 33.
6. Start MULTU and assert reset at cycle 10 → busy, done, hi, lo go to 0 without waiting for a clock edge. After release, MULTU 6×7 → lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. One radix-2 step per cycle,
// then a single sign-fix cycle before results land in hi/lo.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0] count;
  logic [1:0]       op_q;
  logic             sgn_a, sgn_b, dbz_q;
  logic [WIDTH-1:0] oper, acc_hi, acc_lo;

  logic             accept, dbz_req, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_abs, rt_abs;

  assign accept  = start && (state == IDLE || state == DONE);
  assign dbz_req = op[1] && (rt_val == '0);
  assign rs_neg  = op[0] & rs_val[WIDTH-1];
  assign rt_neg  = op[0] & rt_val[WIDTH-1];
  assign rs_abs  = rs_neg ? -rs_val : rs_val;
  assign rt_abs  = rt_neg ? -rt_val : rt_val;

  // Multiply step: conditional add into upper half, then shift whole accumulator right
  logic [WIDTH:0]   mul_sum;
  // Divide step: shift {rem,quot} left, keep the subtraction when it does not underflow
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt;

  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, oper} : '0);
  assign div_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, oper};
  assign rem_nxt = div_ge ? (div_sh[WIDTH-1:0] - oper) : div_sh[WIDTH-1:0];

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = (op_q[0] && (sgn_a ^ sgn_b)) ? -prod : prod;
  assign quot_fix = (op_q[0] && (sgn_a ^ sgn_b)) ? -acc_lo : acc_lo;
  assign rem_fix  = (op_q[0] && sgn_a) ? -acc_hi : acc_hi;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = dbz_req ? DONE : RUN;
    end else begin
      case (state)
        RUN:     if (count == CNT_W'(WIDTH-1)) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      op_q   <= '0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      dbz_q  <= 1'b0;
      oper   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      op_q   <= op;
      sgn_a  <= rs_neg;
      sgn_b  <= rt_neg;
      count  <= '0;
      oper   <= op[1] ? rt_abs : rs_abs;
      acc_lo <= op[1] ? rs_abs : rt_abs;
      acc_hi <= '0;
      dbz_q  <= dbz_req;
      if (dbz_req) begin
        hi <= rs_val;
        lo <= '1;
      end
    end else begin
      case (state)
        RUN: begin
          count <= count + CNT_W'(1);
          if (op_q[1]) begin
            acc_hi <= rem_nxt;
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (op_q[1]) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        DONE:    dbz_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy        = (state == RUN) || (state == FIX);
  assign done        = (state == DONE);
  assign div_by_zero = dbz_q && (state == DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: products, quotients, signs, div-by-zero,
// back-to-back issue, ignored start while busy, and async reset abort.
module tb_muldiv_sequencer;
  logic        clock, reset, start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int nasserts = 0;
  int nfails   = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nasserts++;
    assert (obs === exp) else begin
      nfails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; start is sampled on the next posedge (accept edge).
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clock);
    start = 1'b0; rs_val = 32'hdeadbeef; rt_val = 32'hdeadbeef;
  endtask

  // n = accept-to-sample distance in cycles; bounded so a stuck DUT still ends.
  task automatic wait_done(input int n0, output int n, output int bc);
    n = n0; bc = 0;
    while (done !== 1'b1 && n < 80) begin
      if (busy === 1'b1) bc++;
      @(negedge clock);
      n++;
    end
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                     input int elat, input int ebusy, input logic edbz);
    int n, bc;
    issue(o, a, b);
    wait_done(0, n, bc);
    chk({name, " latency"}, 64'(n), 64'(elat));
    chk({name, " busy_cycles"}, 64'(bc), 64'(ebusy));
    chk({name, " hi"}, 64'(hi), 64'(ehi));
    chk({name, " lo"}, 64'(lo), 64'(elo));
    chk({name, " dbz"}, 64'(div_by_zero), 64'(edbz));
  endtask

  initial begin
    int n, bc;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    #2;
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst dbz",  64'(div_by_zero), 64'(0));
    chk("rst hi",   64'(hi), 64'(0));
    chk("rst lo",   64'(lo), 64'(0));
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 33, 1'b0);
    @(negedge clock);
    chk("done one cycle", 64'(done), 64'(0));
    chk("idle busy", 64'(busy), 64'(0));

    run("mult_neg3x7", 2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 33, 1'b0);
    run("mult_b2b", 2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33, 33, 1'b0);
    @(negedge clock);
    run("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 33, 33, 1'b0);
    @(negedge clock);
    run("div_neg7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33, 1'b0);
    @(negedge clock);
    run("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 33, 1'b0);
    @(negedge clock);
    run("mult_negxneg", 2'b01, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 33, 33, 1'b0);
    run("div_7_neg2", 2'b11, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 33, 1'b0);
    @(negedge clock);

    run("divu_by0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 0, 0, 1'b1);
    @(negedge clock);
    chk("by0 dbz clears", 64'(div_by_zero), 64'(0));
    chk("by0 done clears", 64'(done), 64'(0));
    chk("by0 hi holds", 64'(hi), 64'(5));
    chk("by0 lo holds", 64'(lo), 64'(32'hFFFFFFFF));

    // Second start while busy must be ignored
    issue(2'b10, 32'd100, 32'd7);
    repeat (4) @(negedge clock);
    start = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd3;
    @(negedge clock);
    start = 1'b0;
    wait_done(5, n, bc);
    chk("ignore latency", 64'(n), 64'(33));
    chk("ignore hi", 64'(hi), 64'(2));
    chk("ignore lo", 64'(lo), 64'(14));
    @(negedge clock);
    chk("ignore no restart", 64'(busy), 64'(0));

    // Async reset mid-operation
    issue(2'b00, 32'h00001234, 32'h00005678);
    repeat (9) @(negedge clock);
    chk("pre-rst busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    chk("arst busy", 64'(busy), 64'(0));
    chk("arst done", 64'(done), 64'(0));
    chk("arst hi", 64'(hi), 64'(0));
    chk("arst lo", 64'(lo), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run("multu_6x7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 33, 33, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfails);
    $finish;
  end
endmodule
